// File: rtl/frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// frame_sequencer_if
// Signal bundle between the frame sequencer and its environment (scene
// compositor, colour RAM, VGA adapter). Clock and reset stay plain ports on
// the sequencer.
//
//   iSkipClear  env -> seq  1 = omit CLEAR for the frame starting at this tick
//   iColour     env -> seq  compositor colour for the current oX/oY (same cycle)
//   oX, oY      seq -> env  scan coordinate / colour RAM address
//   oWren       seq -> env  colour RAM write enable
//   oWrData     seq -> env  colour RAM write data
//   oPlot       seq -> env  VGA plot enable, aligned to RAM read data
//   oPlotX/Y    seq -> env  VGA coordinate, aligned to RAM read data
//   oNewFrame   seq -> env  one-cycle pulse in the first cycle of a frame
//   oPhase      seq -> env  current sequencer state code
//   oOverrun    seq -> env  sticky: a tick arrived while a frame was running
//
// master: the sequencer side.  slave: the environment side.
// -----------------------------------------------------------------------------
interface frame_sequencer_if #(
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int COLOUR_W = 3
);
    logic                iSkipClear;
    logic [COLOUR_W-1:0] iColour;
    logic [XW-1:0]       oX;
    logic [YW-1:0]       oY;
    logic                oWren;
    logic [COLOUR_W-1:0] oWrData;
    logic                oPlot;
    logic [XW-1:0]       oPlotX;
    logic [YW-1:0]       oPlotY;
    logic                oNewFrame;
    logic [2:0]          oPhase;
    logic                oOverrun;

    modport master (
        input  iSkipClear, iColour,
        output oX, oY, oWren, oWrData, oPlot, oPlotX, oPlotY,
               oNewFrame, oPhase, oOverrun
    );

    modport slave (
        output iSkipClear, iColour,
        input  oX, oY, oWren, oWrData, oPlot, oPlotX, oPlotY,
               oNewFrame, oPhase, oOverrun
    );
endinterface

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
// Generates the frame tick and, once per frame, raster-scans the colour RAM
// three times back to back: CLEAR (write CLEAR_COLOUR), COMPOSE (write the
// compositor colour), DISPLAY (read and stream to the VGA adapter). A DRAIN
// phase of RD_LATENCY cycles lets the last read data leave the plot pipe.
//
// Ports:
//   iClock   system clock
//   iResetn  synchronous active-low reset
//   bus      frame_sequencer_if.master (scan address, RAM write port, VGA plot
//            port, frame pulse, phase and overrun flag)
//
// RD_LATENCY must lie in 1..4 (drain counter is 3 bits wide).
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int                  WIDTH        = 160,
    parameter int                  HEIGHT       = 120,
    parameter int                  XW           = 8,
    parameter int                  YW           = 7,
    parameter int                  COLOUR_W     = 3,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0,
    parameter int                  FRAME_DIV    = 833333,
    parameter int                  RD_LATENCY   = 1
) (
    input  logic              iClock,
    input  logic              iResetn,
    frame_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        WAIT    = 3'd0,
        CLEAR   = 3'd1,
        COMPOSE = 3'd2,
        DISPLAY = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    localparam int DW = $clog2(FRAME_DIV + 1);

    state_t        state;
    state_t        nextState;
    logic [DW-1:0] divCount;
    logic          tick;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          scanning;
    logic          lastX;
    logic          lastY;
    logic          scanDone;
    logic [2:0]    drainCount;
    logic          drainDone;
    logic          newFrame;
    logic          overrun;

    logic          pipeValid [RD_LATENCY];
    logic [XW-1:0] pipeX     [RD_LATENCY];
    logic [YW-1:0] pipeY     [RD_LATENCY];

    // ---------------------------------------------------------------- divider
    // Free-running; tick is the cycle the counter sits at zero, reload follows.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values regardless of block ordering.
    always_ff @(posedge iClock) begin
        if (!iResetn || divCount == '0) begin
            divCount <= DW'(FRAME_DIV - 1);
        end else begin
            divCount <= divCount - 1'b1;
        end
    end

    assign tick = (divCount == '0);

    // ------------------------------------------------------------ scan counter
    assign scanning = (state == CLEAR) || (state == COMPOSE) || (state == DISPLAY);
    assign lastX    = (x == XW'(WIDTH - 1));
    assign lastY    = (y == YW'(HEIGHT - 1));
    assign scanDone = scanning && lastX && lastY;

    // The wrap at the last pixel returns the counters to (0,0), so the next
    // phase starts on the following cycle without a bubble.
    always_ff @(posedge iClock) begin
        if (!iResetn || !scanning) begin
            x <= '0;
            y <= '0;
        end else if (lastX) begin
            x <= '0;
            y <= lastY ? '0 : y + 1'b1;
        end else begin
            x <= x + 1'b1;
        end
    end

    always_ff @(posedge iClock) begin
        if (!iResetn || state != DRAIN) begin
            drainCount <= '0;
        end else begin
            drainCount <= drainCount + 1'b1;
        end
    end

    assign drainDone = (state == DRAIN) && (drainCount == 3'(RD_LATENCY - 1));

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            state <= WAIT;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: defaults are assigned before the case so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState   = state;
        bus.oWren   = 1'b0;
        bus.oWrData = '0;
        unique case (state)
            WAIT: begin
                if (tick) begin
                    nextState = bus.iSkipClear ? COMPOSE : CLEAR;
                end
            end
            CLEAR: begin
                bus.oWren   = 1'b1;
                bus.oWrData = CLEAR_COLOUR;
                if (scanDone) nextState = COMPOSE;
            end
            COMPOSE: begin
                bus.oWren   = 1'b1;
                bus.oWrData = bus.iColour;
                if (scanDone) nextState = DISPLAY;
            end
            DISPLAY: begin
                if (scanDone) nextState = DRAIN;
            end
            DRAIN: begin
                if (drainDone) nextState = WAIT;
            end
            default: nextState = WAIT;
        endcase
    end

    // ------------------------------------------------------- frame and overrun
    // A tick in any state but WAIT (including DRAIN's last cycle) is dropped
    // and flagged; the running frame is not disturbed.
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            newFrame <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            newFrame <= tick && (state == WAIT);
            if (tick && state != WAIT) begin
                overrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ plot pipe
    // Matches the colour RAM read latency: an address issued in cycle C shows
    // up as a plot in cycle C + RD_LATENCY. Coordinates are zeroed when not
    // valid so the VGA port is quiet outside the burst.
    // NOTE: the pipe is tiny and feeds outputs directly, so it is reset in
    // full; that keeps oPlot/oPlotX/oPlotY at 0 right after reset.
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipeValid[i] <= 1'b0;
                pipeX[i]     <= '0;
                pipeY[i]     <= '0;
            end
        end else begin
            pipeValid[0] <= (state == DISPLAY);
            pipeX[0]     <= (state == DISPLAY) ? x : '0;
            pipeY[0]     <= (state == DISPLAY) ? y : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeX[i]     <= pipeX[i-1];
                pipeY[i]     <= pipeY[i-1];
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.oX        = x;
    assign bus.oY        = y;
    assign bus.oPlot     = pipeValid[RD_LATENCY-1];
    assign bus.oPlotX    = pipeX[RD_LATENCY-1];
    assign bus.oPlotY    = pipeY[RD_LATENCY-1];
    assign bus.oNewFrame = newFrame;
    assign bus.oPhase    = state;
    assign bus.oOverrun  = overrun;

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Parametrised frame sequencer for the VGA pipeline. It generates the frame tick internally, then per frame runs a raster scan through three phases: clear the colour RAM, compose the scene into it, and stream it out to the VGA adapter. It replaces the hard-wired 160×120 scanner and its free-running control FSM with a gap-free phase sequence, a read-latency-matched plot path and frame-overrun detection. It sits between the scene compositor (which supplies colour per coordinate), the colour RAM and the VGA adapter.

## Interface
Parameters:
- WIDTH, 160, pixels per line
- HEIGHT, 120, lines per frame
- XW, 8, x coordinate width; must satisfy 2^XW ≥ WIDTH
- YW, 7, y coordinate width; must satisfy 2^YW ≥ HEIGHT
- COLOUR_W, 3, colour width
- CLEAR_COLOUR, 3'd0, value written during CLEAR
- FRAME_DIV, 833333, clock cycles per frame tick (50 MHz / 60)
- RD_LATENCY, 1, colour RAM read latency in cycles; legal range 1..4

Ports:
- iClock  in  1  system clock
- iResetn  in  1  reset, synchronous, active-low
- iSkipClear  in  1  sampled on frame start; 1 = omit the CLEAR phase for that frame
- iColour  in  COLOUR_W  compositor colour for the current oX/oY; must be combinational, same cycle
- oX  out  XW  scan x, which is also the RAM address low part
- oY  out  YW  scan y, which is also the RAM address high part
- oWren  out  1  RAM write enable
- oWrData  out  COLOUR_W  RAM write data
- oPlot  out  1  VGA plot enable
- oPlotX  out  XW  VGA x, aligned to RAM read data
- oPlotY  out  YW  VGA y, aligned to RAM read data
- oNewFrame  out  1  one-cycle pulse when a frame is started
- oPhase  out  3  current state encoding
- oOverrun  out  1  sticky; set when a tick arrives while the sequencer is busy

## Operation
- **States:** WAIT=0, CLEAR=1, COMPOSE=2, DISPLAY=3, DRAIN=4.
- **Tick divider:**
  - Down-counter loaded with FRAME_DIV−1 on reset.
  - The tick is asserted in the cycle the counter is 0; the counter reloads on the next cycle.
  - The divider free-runs and is independent of state.
- **WAIT:**
  - On tick: go to CLEAR, or to COMPOSE if iSkipClear=1 in the tick cycle.
  - oNewFrame=1 in the first cycle of the new state.
- **Tick outside WAIT:** the tick is ignored, oOverrun is set to 1, and the current frame continues unaffected.
- **Scan:**
  - Raster order; x increments each cycle.
  - At x=WIDTH−1, x wraps to 0 and y increments.
  - At (WIDTH−1, HEIGHT−1) the phase ends; the next state starts at (0,0) on the following cycle with no bubble.
  - x and y never exceed WIDTH−1 and HEIGHT−1.
  - Each scanning phase lasts exactly WIDTH·HEIGHT cycles.
- **CLEAR:** oWren=1, oWrData=CLEAR_COLOUR.
- **COMPOSE:** oWren=1, oWrData=iColour (combinational pass-through).
- **DISPLAY:**
  - oWren=0 and oX/oY act as the read address.
  - {valid, x, y} enter a RD_LATENCY-deep shift register.
  - oPlot, oPlotX and oPlotY are the shift register's output.
- **DRAIN:**
  - Lasts RD_LATENCY cycles with oX=oY=0 and no new valid entries.
  - Then goes to WAIT.
- **WAIT outputs:** oWren=0, oX=oY=0, oWrData=0.
- **oPhase:** equals the state code.
- **Reset:**
  - Sets state=WAIT, x=y=0, clears the shift register, reloads the divider, and clears oOverrun.
  - Every output is 0 in the cycle after reset is sampled low.
  - Reset mid-phase aborts immediately; no further writes or plots occur.

## Timing
- All state, scan counters, shift register and flags are registered on posedge iClock.
- oWrData is combinational in COMPOSE only.
- Frame start: tick in cycle T → state≠WAIT and oNewFrame=1 in T+1 → first pixel (0,0) at T+1.
- Frame length:
  - (3·WIDTH·HEIGHT) + RD_LATENCY cycles from start to WAIT.
  - (2·WIDTH·HEIGHT) + RD_LATENCY cycles with skip-clear.
- Plot alignment: a pixel addressed at cycle C has oPlot=1 with the same coordinates at cycle C+RD_LATENCY.
- Plot burst: oPlot is high for exactly WIDTH·HEIGHT consecutive cycles per frame.
- A tick in the same cycle that DRAIN exits to WAIT counts as busy: overrun is set and no frame starts.

## Test plan
- **Nominal frame** (WIDTH=4, HEIGHT=3, FRAME_DIV=64, RD_LATENCY=2): oNewFrame at cycle 64 → 12 CLEAR writes of 0, then 12 COMPOSE writes equal to iColour=f(x,y), 12 plots starting 2 cycles after DISPLAY entry with oPlotX/Y in raster order. Back in WAIT after 38 cycles; oOverrun=0.
- **Skip clear:** iSkipClear=1 at tick → no CLEAR, COMPOSE begins at T+1, WAIT reached after 26 cycles.
- **Overrun** (FRAME_DIV=30, same size): the second tick arrives during DISPLAY → oOverrun=1 and stays 1. No frame start at that tick; the next frame starts at tick 3.
- **Wrap check:** over the full frame, oX∈[0,3] and oY∈[0,2] at all times; the (3,0)→(0,1) and (3,2)→next-phase (0,0) transitions occur on consecutive cycles.
- **Reset mid-COMPOSE:** iResetn=0 for 1 cycle at pixel (2,1) → next cycle all outputs 0, state WAIT, oOverrun=0. The next oNewFrame is exactly FRAME_DIV cycles after reset release.
- **Latency sweep:** RD_LATENCY=1 and 4 → plot offset equals RD_LATENCY, DRAIN length equals RD_LATENCY, and the plot count is 12.
